io_bus_master: RTL and testbench

//  Initiator side of the 8-bit I/O peripheral bus (address/din/dout/w_en/r_en) used by gpio and sibling peripherals.

---
 rtl/io_bus_master.sv | 184 ++++++++++++++++++
 tb/tb_io_bus_master.sv | 465 ++++++++++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/io_bus_master.sv
// io_bus_master: initiator side of the 8-bit peripheral I/O bus.
// Commands arrive on a valid/ready channel and are queued in a small FIFO.
// Each command is issued as a single-cycle w_en or r_en strobe. Read data is
// captured a fixed number of cycles after the strobe and returned on a
// valid/ready response channel.
module io_bus_master #(
    parameter int FIFO_DEPTH   = 4,
    parameter int READ_LATENCY = 1
) (
    input  logic       clk,
    input  logic       rst,
    input  logic       cmd_valid,
    output logic       cmd_ready,
    input  logic       cmd_write,
    input  logic [7:0] cmd_addr,
    input  logic [7:0] cmd_wdata,
    output logic       rsp_valid,
    input  logic       rsp_ready,
    output logic [7:0] rsp_data,
    output logic       busy,
    output logic [7:0] address,
    output logic [7:0] dout,
    output logic       w_en,
    output logic       r_en,
    input  logic [7:0] din
);

    localparam int PTR_W = (FIFO_DEPTH > 1) ? $clog2(FIFO_DEPTH) : 1;
    localparam int CNT_W = PTR_W + 1;
    localparam int LAT_W = (READ_LATENCY > 1) ? $clog2(READ_LATENCY + 1) : 1;
    localparam logic [CNT_W-1:0] FULL_COUNT = CNT_W'(FIFO_DEPTH);
    localparam logic [LAT_W-1:0] LAT_LOAD   = LAT_W'(READ_LATENCY);
    localparam logic [LAT_W-1:0] LAT_LAST   = LAT_W'(1);

    typedef enum logic [1:0] {
        S_IDLE,
        S_STROBE,
        S_WAIT,
        S_RESP
    } state_t;

    typedef struct packed {
        logic       write;
        logic [7:0] addr;
        logic [7:0] wdata;
    } cmd_t;

    // Command FIFO
    cmd_t             r_mem [FIFO_DEPTH];
    logic [PTR_W-1:0] r_wr_ptr;
    logic [PTR_W-1:0] r_rd_ptr;
    logic [CNT_W-1:0] r_count;
    logic             r_cmd_ready;
    logic             r_busy;

    // Bus sequencer
    state_t           r_state;
    logic [7:0]       r_address;
    logic [7:0]       r_dout;
    logic             r_w_en;
    logic             r_r_en;
    logic             r_rsp_valid;
    logic [7:0]       r_rsp_data;
    logic [LAT_W-1:0] r_lat_cnt;

    logic             w_push;
    logic             w_pop;
    logic [CNT_W-1:0] w_count_next;
    logic             w_idle_next;
    cmd_t             w_head;

    assign w_push       = cmd_valid && r_cmd_ready;
    assign w_pop        = (r_state == S_IDLE) && (r_count != '0);
    assign w_count_next = r_count + CNT_W'(w_push) - CNT_W'(w_pop);
    assign w_head       = r_mem[r_rd_ptr];

    // Predict whether the sequencer will sit in IDLE after this edge (feeds busy)
    always_comb begin
        // NOTE: default first so every path assigns and no latch is inferred.
        w_idle_next = 1'b0;
        case (r_state)
            S_IDLE:   w_idle_next = !w_pop;
            S_STROBE: w_idle_next = !r_r_en;
            S_WAIT:   w_idle_next = 1'b0;
            S_RESP:   w_idle_next = rsp_ready;
            default:  w_idle_next = 1'b1;
        endcase
    end

    // FIFO storage: data only, validity is tracked by the pointers and count
    always_ff @(posedge clk) begin
        // NOTE: storage has no reset; the flushed pointers make stale entries unreachable.
        if (w_push) begin
            r_mem[r_wr_ptr] <= {cmd_write, cmd_addr, cmd_wdata};
        end
    end

    // FIFO pointers, occupancy and the registered ready/busy flags
    always_ff @(posedge clk or posedge rst) begin
        // NOTE: non-blocking assignments so every register samples pre-edge values.
        if (rst) begin
            r_wr_ptr    <= '0;
            r_rd_ptr    <= '0;
            r_count     <= '0;
            r_cmd_ready <= 1'b1;
            r_busy      <= 1'b0;
        end else begin
            if (w_push) begin
                r_wr_ptr <= r_wr_ptr + PTR_W'(1);
            end
            if (w_pop) begin
                r_rd_ptr <= r_rd_ptr + PTR_W'(1);
            end
            r_count     <= w_count_next;
            r_cmd_ready <= (w_count_next != FULL_COUNT);
            r_busy      <= !(w_idle_next && (w_count_next == '0));
        end
    end

    // Bus sequencer: issue one strobe per command, then wait for and return read data
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_state     <= S_IDLE;
            r_address   <= '0;
            r_dout      <= '0;
            r_w_en      <= 1'b0;
            r_r_en      <= 1'b0;
            r_rsp_valid <= 1'b0;
            r_rsp_data  <= '0;
            r_lat_cnt   <= '0;
        end else begin
            case (r_state)
                S_IDLE: begin
                    if (w_pop) begin
                        r_address <= w_head.addr;
                        if (w_head.write) begin
                            r_dout <= w_head.wdata;
                            r_w_en <= 1'b1;
                        end else begin
                            r_r_en <= 1'b1;
                        end
                        r_state <= S_STROBE;
                    end
                end
                S_STROBE: begin
                    r_w_en <= 1'b0;
                    r_r_en <= 1'b0;
                    if (r_r_en) begin
                        r_lat_cnt <= LAT_LOAD;
                        r_state   <= S_WAIT;
                    end else begin
                        r_state <= S_IDLE;
                    end
                end
                S_WAIT: begin
                    if (r_lat_cnt == LAT_LAST) begin
                        r_rsp_data  <= din;
                        r_rsp_valid <= 1'b1;
                        r_state     <= S_RESP;
                    end else begin
                        r_lat_cnt <= r_lat_cnt - LAT_LAST;
                    end
                end
                S_RESP: begin
                    if (rsp_ready) begin
                        r_rsp_valid <= 1'b0;
                        r_state     <= S_IDLE;
                    end
                end
                default: r_state <= S_IDLE;
            endcase
        end
    end

    assign cmd_ready = r_cmd_ready;
    assign busy      = r_busy;
    assign address   = r_address;
    assign dout      = r_dout;
    assign w_en      = r_w_en;
    assign r_en      = r_r_en;
    assign rsp_valid = r_rsp_valid;
    assign rsp_data  = r_rsp_data;

endmodule

// File: tb/tb_io_bus_master.sv
// tb_io_bus_master: directed scenarios plus randomized traffic for io_bus_master.
// A registered peripheral model answers reads; a queue-based reference model
// predicts bus transactions and read responses from the accepted commands.
module tb_io_bus_master;

    localparam int DEPTH  = 4;
    localparam int N_RUN  = 1500;
    localparam int N_LIM  = 1800;

    typedef struct packed {
        logic       wr;
        logic [7:0] addr;
        logic [7:0] data;
    } op_t;

    logic clk = 1'b0;
    logic rst;
    always #5 clk = ~clk;

    int n_cmp = 0;
    int n_err = 0;

    // Main DUT (READ_LATENCY = 1)
    logic       cmd_valid, cmd_ready, cmd_write;
    logic [7:0] cmd_addr, cmd_wdata;
    logic       rsp_valid, rsp_ready;
    logic [7:0] rsp_data;
    logic       busy, w_en, r_en;
    logic [7:0] address, dout, din;

    // Second DUT (READ_LATENCY = 3)
    logic       b_cmd_valid, b_cmd_ready, b_cmd_write;
    logic [7:0] b_cmd_addr, b_cmd_wdata;
    logic       b_rsp_valid, b_rsp_ready;
    logic [7:0] b_rsp_data;
    logic       b_busy, b_w_en, b_r_en;
    logic [7:0] b_address, b_dout, b_din;

    io_bus_master #(.FIFO_DEPTH(DEPTH), .READ_LATENCY(1)) dut (
        .clk(clk), .rst(rst),
        .cmd_valid(cmd_valid), .cmd_ready(cmd_ready), .cmd_write(cmd_write),
        .cmd_addr(cmd_addr), .cmd_wdata(cmd_wdata),
        .rsp_valid(rsp_valid), .rsp_ready(rsp_ready), .rsp_data(rsp_data),
        .busy(busy), .address(address), .dout(dout),
        .w_en(w_en), .r_en(r_en), .din(din)
    );

    io_bus_master #(.FIFO_DEPTH(DEPTH), .READ_LATENCY(3)) dut3 (
        .clk(clk), .rst(rst),
        .cmd_valid(b_cmd_valid), .cmd_ready(b_cmd_ready), .cmd_write(b_cmd_write),
        .cmd_addr(b_cmd_addr), .cmd_wdata(b_cmd_wdata),
        .rsp_valid(b_rsp_valid), .rsp_ready(b_rsp_ready), .rsp_data(b_rsp_data),
        .busy(b_busy), .address(b_address), .dout(b_dout),
        .w_en(b_w_en), .r_en(b_r_en), .din(b_din)
    );

    // Registered peripheral: data valid only in the cycle after r_en, junk otherwise
    logic [7:0] pmem [256];
    always @(posedge clk) begin
        if (w_en) pmem[address] <= dout;
        din <= r_en ? pmem[address] : 8'($urandom);
    end

    // Slow peripheral for dut3: 0x00 until 3 cycles after r_en, then 0xC3 for one cycle
    int b_cnt = 0;
    always @(posedge clk) begin
        if (b_r_en) b_cnt <= 1;
        else if (b_cnt != 0 && b_cnt < 7) b_cnt <= b_cnt + 1;
        else b_cnt <= 0;
    end
    assign b_din = (b_cnt == 3) ? 8'hC3 : 8'h00;

    task automatic send_cmd(input logic wr, input logic [7:0] a, input logic [7:0] d);
        logic ok;
        ok = 1'b0;
        cmd_valid = 1'b1; cmd_write = wr; cmd_addr = a; cmd_wdata = d;
        for (int k = 0; k < 100 && !ok; k++) begin
            @(negedge clk);
            ok = cmd_ready;
            @(posedge clk); #1;
        end
        cmd_valid = 1'b0;
        if (!ok) begin
            n_cmp++; n_err++;
            $display("FAIL send_cmd: command to %h never accepted", a);
        end
    endtask

    task automatic wait_idle();
        logic done;
        done = 1'b0;
        rsp_ready = 1'b1;
        for (int k = 0; k < 60 && !done; k++) begin
            @(negedge clk);
            done = !busy && !rsp_valid;
            @(posedge clk); #1;
        end
        if (!done) begin
            n_cmp++; n_err++;
            $display("FAIL wait_idle: DUT still busy after 60 cycles");
        end
    endtask

    task automatic test_reset();
        n_cmp++;
        if ({cmd_ready, rsp_valid, rsp_data, busy, address, dout, w_en, r_en} !== {1'b1, 1'b0, 8'h00, 1'b0, 8'h00, 8'h00, 1'b0, 1'b0}) begin
            n_err++;
            $display("FAIL reset_state: got rdy=%b rv=%b rd=%h busy=%b a=%h d=%h w=%b r=%b expected rdy=1 others 0",
                     cmd_ready, rsp_valid, rsp_data, busy, address, dout, w_en, r_en);
        end
        n_cmp++;
        if ({b_cmd_ready, b_rsp_valid, b_rsp_data, b_busy, b_address, b_dout, b_w_en, b_r_en} !== {1'b1, 1'b0, 8'h00, 1'b0, 8'h00, 8'h00, 1'b0, 1'b0}) begin
            n_err++;
            $display("FAIL reset_state_lat3: got rdy=%b rv=%b busy=%b w=%b r=%b expected rdy=1 others 0",
                     b_cmd_ready, b_rsp_valid, b_busy, b_w_en, b_r_en);
        end
    endtask

    task automatic test_write_single();
        int wcnt, wpos;
        logic other;
        logic [7:0] a_at, d_at;
        wcnt = 0; wpos = -1; other = 1'b0; a_at = '0; d_at = '0;
        rsp_ready = 1'b1;
        cmd_valid = 1'b1; cmd_write = 1'b1; cmd_addr = 8'h01; cmd_wdata = 8'hFF;
        for (int k = 0; k < 6; k++) begin
            @(negedge clk);
            if (w_en) begin wcnt++; wpos = k; a_at = address; d_at = dout; end
            if (r_en || rsp_valid) other = 1'b1;
            @(posedge clk); #1;
            cmd_valid = 1'b0;
        end
        n_cmp++;
        if (wcnt != 1 || wpos != 2) begin
            n_err++; $display("FAIL write_strobe: got %0d pulses at cycle %0d expected 1 pulse at cycle 2", wcnt, wpos);
        end
        n_cmp++;
        if ({a_at, d_at} !== 16'h01FF) begin
            n_err++; $display("FAIL write_bus: got addr=%h dout=%h expected addr=01 dout=ff", a_at, d_at);
        end
        n_cmp++;
        if (other !== 1'b0) begin
            n_err++; $display("FAIL write_no_rsp: got r_en/rsp_valid activity expected none");
        end
        n_cmp++;
        if ({busy, address, dout} !== {1'b0, 8'h01, 8'hFF}) begin
            n_err++; $display("FAIL write_hold: got busy=%b addr=%h dout=%h expected 0 01 ff", busy, address, dout);
        end
    endtask

    task automatic test_read_single();
        int rpos, vpos, vcnt;
        logic [7:0] vdata;
        send_cmd(1'b1, 8'h02, 8'h5A);
        wait_idle();
        rpos = -1; vpos = -1; vcnt = 0; vdata = '0;
        rsp_ready = 1'b1;
        cmd_valid = 1'b1; cmd_write = 1'b0; cmd_addr = 8'h02; cmd_wdata = 8'h00;
        for (int k = 0; k < 10; k++) begin
            @(negedge clk);
            if (r_en) rpos = k;
            if (rsp_valid) begin vcnt++; if (vpos < 0) vpos = k; vdata = rsp_data; end
            @(posedge clk); #1;
            cmd_valid = 1'b0;
        end
        n_cmp++;
        if (rpos != 2 || vpos != 4 || vcnt != 1) begin
            n_err++; $display("FAIL read_timing: got r_en@%0d rsp@%0d x%0d expected r_en@2 rsp@4 x1", rpos, vpos, vcnt);
        end
        n_cmp++;
        if (vdata !== 8'h5A) begin
            n_err++; $display("FAIL read_data: got %h expected 5a", vdata);
        end
    endtask

    task automatic test_fifo_full();
        logic [7:0] wd [4];
        int pos[$];
        logic [7:0] ga[$];
        logic [7:0] gd[$];
        logic stall_bad;
        rsp_ready = 1'b0;
        send_cmd(1'b0, 8'h02, 8'h00);
        for (int i = 0; i < 4; i++) begin
            wd[i] = 8'($urandom);
            send_cmd(1'b1, 8'(8'h30 + i), wd[i]);
        end
        stall_bad = 1'b0;
        for (int k = 0; k < 5; k++) begin
            @(negedge clk);
            if (k == 0) begin
                n_cmp++;
                if (cmd_ready !== 1'b0) begin
                    n_err++; $display("FAIL full_ready: got cmd_ready=%b expected 0", cmd_ready);
                end
            end
            if (cmd_ready || !rsp_valid || w_en || r_en || !busy) stall_bad = 1'b1;
            @(posedge clk); #1;
        end
        n_cmp++;
        if (stall_bad !== 1'b0) begin
            n_err++; $display("FAIL full_stall: got activity while response pending expected held state");
        end
        n_cmp++;
        if (rsp_data !== 8'h5A) begin
            n_err++; $display("FAIL full_rsp_data: got %h expected 5a", rsp_data);
        end
        rsp_ready = 1'b1;
        for (int k = 0; k < 20; k++) begin
            @(negedge clk);
            if (w_en) begin pos.push_back(k); ga.push_back(address); gd.push_back(dout); end
            @(posedge clk); #1;
        end
        n_cmp++;
        if (ga.size() != 4) begin
            n_err++; $display("FAIL full_write_count: got %0d expected 4", ga.size());
        end
        for (int i = 0; i < ga.size() && i < 4; i++) begin
            n_cmp++;
            if ({ga[i], gd[i]} !== {8'(8'h30 + i), wd[i]}) begin
                n_err++; $display("FAIL full_order[%0d]: got %h/%h expected %h/%h", i, ga[i], gd[i], 8'(8'h30 + i), wd[i]);
            end
        end
        n_cmp++;
        if ({cmd_ready, busy} !== 2'b10) begin
            n_err++; $display("FAIL full_drain: got rdy=%b busy=%b expected 1 0", cmd_ready, busy);
        end
    endtask

    task automatic test_read_latency3();
        int rpos, vpos, vcnt;
        logic [7:0] vdata;
        rpos = -1; vpos = -1; vcnt = 0; vdata = '0;
        b_rsp_ready = 1'b1;
        b_cmd_valid = 1'b1; b_cmd_write = 1'b0; b_cmd_addr = 8'h44; b_cmd_wdata = 8'h00;
        for (int k = 0; k < 12; k++) begin
            @(negedge clk);
            if (b_r_en) rpos = k;
            if (b_rsp_valid) begin vcnt++; if (vpos < 0) vpos = k; vdata = b_rsp_data; end
            @(posedge clk); #1;
            b_cmd_valid = 1'b0;
        end
        n_cmp++;
        if (rpos != 2 || vpos != 6 || vcnt != 1) begin
            n_err++; $display("FAIL lat3_timing: got r_en@%0d rsp@%0d x%0d expected r_en@2 rsp@6 x1", rpos, vpos, vcnt);
        end
        n_cmp++;
        if (vdata !== 8'hC3) begin
            n_err++; $display("FAIL lat3_data: got %h expected c3", vdata);
        end
        n_cmp++;
        if (b_busy !== 1'b0) begin
            n_err++; $display("FAIL lat3_idle: got busy=%b expected 0", b_busy);
        end
    endtask

    task automatic test_reset_mid_wait();
        logic bad;
        rsp_ready = 1'b1;
        cmd_valid = 1'b1; cmd_write = 1'b0; cmd_addr = 8'h02; cmd_wdata = 8'h00;
        @(posedge clk); #1;
        cmd_valid = 1'b0;
        @(posedge clk); #1;
        n_cmp++;
        if (r_en !== 1'b1) begin
            n_err++; $display("FAIL rstw_strobe: got r_en=%b expected 1", r_en);
        end
        @(posedge clk); #1;
        n_cmp++;
        if ({r_en, rsp_valid, busy} !== 3'b001) begin
            n_err++; $display("FAIL rstw_wait: got r_en/rv/busy=%b expected 001", {r_en, rsp_valid, busy});
        end
        rst = 1'b1;
        #1;
        n_cmp++;
        if ({w_en, r_en, rsp_valid, busy, cmd_ready} !== 5'b00001) begin
            n_err++; $display("FAIL rstw_async: got w/r/rv/busy/rdy=%b expected 00001", {w_en, r_en, rsp_valid, busy, cmd_ready});
        end
        @(posedge clk); #1;
        rst = 1'b0;
        bad = 1'b0;
        for (int k = 0; k < 10; k++) begin
            @(negedge clk);
            if (rsp_valid || r_en || w_en || busy) bad = 1'b1;
            @(posedge clk); #1;
        end
        n_cmp++;
        if (bad !== 1'b0) begin
            n_err++; $display("FAIL rstw_quiet: got activity after reset expected none");
        end
    endtask

    task automatic test_back_to_back();
        logic [7:0] wd [4];
        int pos[$];
        logic [7:0] ga[$];
        logic [7:0] gd[$];
        int idx;
        logic acc, other;
        for (int i = 0; i < 4; i++) wd[i] = 8'($urandom);
        idx = 0; other = 1'b0;
        rsp_ready = 1'b1;
        cmd_valid = 1'b1; cmd_write = 1'b1; cmd_addr = 8'h10; cmd_wdata = wd[0];
        for (int k = 0; k < 16; k++) begin
            @(negedge clk);
            if (w_en) begin pos.push_back(k); ga.push_back(address); gd.push_back(dout); end
            if (r_en) other = 1'b1;
            acc = cmd_valid && cmd_ready;
            @(posedge clk); #1;
            if (acc) idx++;
            if (idx < 4) begin
                cmd_addr = 8'(8'h10 + idx); cmd_wdata = wd[idx];
            end else begin
                cmd_valid = 1'b0;
            end
        end
        n_cmp++;
        if (pos.size() != 4 || other) begin
            n_err++; $display("FAIL b2b_count: got %0d writes (read seen=%b) expected 4 writes", pos.size(), other);
        end
        for (int i = 0; i < pos.size() && i < 4; i++) begin
            n_cmp++;
            if (pos[i] != 2 + 2 * i || {ga[i], gd[i]} !== {8'(8'h10 + i), wd[i]}) begin
                n_err++; $display("FAIL b2b[%0d]: got cycle %0d %h/%h expected cycle %0d %h/%h",
                                  i, pos[i], ga[i], gd[i], 2 + 2 * i, 8'(8'h10 + i), wd[i]);
            end
        end
    endtask

    task automatic test_random();
        op_t exp_ops[$];
        logic [7:0] exp_rsp[$];
        logic [7:0] exp_mem [16];
        op_t pend, got;
        logic have_pend, drained, strb;
        logic prev_strb, prev_rv, prev_rr;
        logic [7:0] prev_rd, exp_d;
        int sent, n_acc, n_strb, occ, exp_rise;
        have_pend = 1'b0; drained = 1'b0; pend = '0;
        prev_strb = 1'b0; prev_rv = 1'b0; prev_rr = 1'b0; prev_rd = '0;
        sent = 0; n_acc = 0; n_strb = 0; exp_rise = -1;
        for (int i = 0; i < 16; i++) exp_mem[i] = '0;
        for (int c = 0; c < N_LIM && !drained; c++) begin
            if (c < N_RUN) begin
                if (!have_pend && $urandom_range(0, 9) < 6) begin
                    pend.wr   = (sent < 16) ? 1'b1 : 1'($urandom_range(0, 1));
                    pend.addr = (sent < 16) ? 8'(sent) : 8'($urandom_range(0, 15));
                    pend.data = 8'($urandom);
                    have_pend = 1'b1;
                end
                cmd_valid = have_pend;
                cmd_write = pend.wr; cmd_addr = pend.addr; cmd_wdata = pend.data;
                rsp_ready = 1'($urandom_range(0, 1));
            end else begin
                have_pend = 1'b0;
                cmd_valid = 1'b0;
                rsp_ready = 1'b1;
            end
            @(negedge clk);
            strb = w_en || r_en;
            n_cmp++;
            if (w_en && r_en) begin
                n_err++; $display("FAIL rnd_both_strobes: cycle %0d w_en and r_en both high", c);
            end
            if (strb) begin
                n_strb++;
                n_cmp++;
                if (prev_strb) begin
                    n_err++; $display("FAIL rnd_strobe_gap: cycle %0d strobe follows strobe", c);
                end
                n_cmp++;
                if (exp_ops.size() == 0) begin
                    n_err++; $display("FAIL rnd_unexpected_op: cycle %0d addr=%h with nothing queued", c, address);
                end else begin
                    got = exp_ops.pop_front();
                    if ({w_en, address, got.wr ? dout : 8'h00} !== {got.wr, got.addr, got.wr ? got.data : 8'h00}) begin
                        n_err++; $display("FAIL rnd_bus_op: cycle %0d got w=%b a=%h d=%h expected w=%b a=%h d=%h",
                                          c, w_en, address, dout, got.wr, got.addr, got.data);
                    end
                end
                if (r_en) exp_rise = c + 2;
            end
            if (rsp_valid && !prev_rv) begin
                n_cmp++;
                if (c != exp_rise) begin
                    n_err++; $display("FAIL rnd_rsp_latency: rsp_valid rose at %0d expected %0d", c, exp_rise);
                end
            end
            if (prev_rv && !prev_rr) begin
                n_cmp++;
                if (!rsp_valid || rsp_data !== prev_rd) begin
                    n_err++; $display("FAIL rnd_rsp_hold: cycle %0d got rv=%b rd=%h expected rv=1 rd=%h", c, rsp_valid, rsp_data, prev_rd);
                end
            end
            if (rsp_valid && rsp_ready) begin
                n_cmp++;
                if (exp_rsp.size() == 0) begin
                    n_err++; $display("FAIL rnd_unexpected_rsp: cycle %0d data=%h", c, rsp_data);
                end else begin
                    exp_d = exp_rsp.pop_front();
                    if (rsp_data !== exp_d) begin
                        n_err++; $display("FAIL rnd_rsp_data: cycle %0d got %h expected %h", c, rsp_data, exp_d);
                    end
                end
            end
            occ = n_acc - n_strb;
            n_cmp++;
            if (cmd_ready !== (occ != DEPTH)) begin
                n_err++; $display("FAIL rnd_cmd_ready: cycle %0d got %b with %0d queued", c, cmd_ready, occ);
            end
            if (occ != 0) begin
                n_cmp++;
                if (busy !== 1'b1) begin
                    n_err++; $display("FAIL rnd_busy: cycle %0d got busy=0 with %0d queued", c, occ);
                end
            end
            if (cmd_valid && cmd_ready) begin
                exp_ops.push_back(pend);
                if (pend.wr) exp_mem[pend.addr[3:0]] = pend.data;
                else exp_rsp.push_back(exp_mem[pend.addr[3:0]]);
                have_pend = 1'b0;
                sent++;
                n_acc++;
            end
            prev_strb = strb; prev_rv = rsp_valid; prev_rr = rsp_ready; prev_rd = rsp_data;
            drained = (c >= N_RUN) && exp_ops.size() == 0 && exp_rsp.size() == 0 && !busy && !rsp_valid;
            @(posedge clk); #1;
        end
        n_cmp++;
        if (!drained) begin
            n_err++; $display("FAIL rnd_drain: got %0d ops / %0d responses outstanding expected 0", exp_ops.size(), exp_rsp.size());
        end
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        rst = 1'b1;
        cmd_valid = 1'b0; cmd_write = 1'b0; cmd_addr = '0; cmd_wdata = '0; rsp_ready = 1'b1;
        b_cmd_valid = 1'b0; b_cmd_write = 1'b0; b_cmd_addr = '0; b_cmd_wdata = '0; b_rsp_ready = 1'b1;
        #2;
        test_reset();
        @(posedge clk); #1;
        rst = 1'b0;
        @(posedge clk); #1;
        test_write_single();
        wait_idle();
        test_read_single();
        wait_idle();
        test_fifo_full();
        wait_idle();
        test_read_latency3();
        test_reset_mid_wait();
        test_back_to_back();
        wait_idle();
        test_random();
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule
